// File: rtl/sim_intr_pkg.sv
// Shared types for the simulation interrupt scheduler: FSM states, channel modes, channel config.
// No logic of its own; CFG_W must match the CNT_W used by the scheduler instance.
package sim_intr_pkg;

    localparam int CFG_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_WINDOW   = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_HOLD_ACK = 2'd3
    } intr_mode_e;

    typedef struct packed {
        intr_mode_e       mode;
        logic [CFG_W-1:0] start;
        logic [CFG_W-1:0] len;
        logic [CFG_W-1:0] period;
    } chan_cfg_t;

endpackage

// File: rtl/sim_intr_chan.sv
// One interrupt channel: config registers, phase counter, sticky flag; o_intr registered, aligned with cycle.
// Latency: o_intr follows i_cycle_nxt on the same edge; ack clears HOLD_ACK one edge after sampling; no backpressure.
module sim_intr_chan
    import sim_intr_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_cfg_we,
    input  chan_cfg_t        i_cfg,
    input  logic             i_enter,
    input  logic             i_adv,
    input  logic [CNT_W-1:0] i_cycle_nxt,
    input  logic             i_ack,
    output logic             o_intr
);

    chan_cfg_t        r_cfg;
    logic [CNT_W-1:0] r_phase;
    logic             r_hold;
    logic             r_intr;

    logic [CNT_W-1:0] w_start;
    logic [CNT_W-1:0] w_len;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_diff;
    logic [CNT_W-1:0] w_phase_nxt;
    logic             w_step;
    logic             w_at_start;
    logic             w_after_start;
    logic             w_win;
    logic             w_hold_nxt;
    logic             w_intr_nxt;

    assign w_start       = CNT_W'(r_cfg.start);
    assign w_len         = CNT_W'(r_cfg.len);
    assign w_period      = CNT_W'(r_cfg.period);
    assign w_step        = i_enter | i_adv;
    assign w_at_start    = (i_cycle_nxt == w_start);
    assign w_after_start = (i_cycle_nxt >= w_start);
    // Difference form keeps start+len from ever overflowing the counter width.
    assign w_diff        = i_cycle_nxt - w_start;
    assign w_win         = w_after_start && (w_diff < w_len);

    always_comb begin
        w_phase_nxt = r_phase;
        if (w_step) begin
            if (w_at_start || !w_after_start) begin
                w_phase_nxt = '0;
            end else if (r_phase == (w_period - 1'b1)) begin
                w_phase_nxt = '0;
            end else begin
                w_phase_nxt = r_phase + 1'b1;
            end
        end
    end

    // Setting at start beats a simultaneous ack, so the ack is applied first.
    always_comb begin
        w_hold_nxt = r_hold;
        if (i_enter || i_ack) begin
            w_hold_nxt = 1'b0;
        end
        if (w_step && (r_cfg.mode == MODE_HOLD_ACK) && w_at_start) begin
            w_hold_nxt = 1'b1;
        end
    end

    always_comb begin
        w_intr_nxt = 1'b0;
        if (w_step) begin
            case (r_cfg.mode)
                MODE_WINDOW:   w_intr_nxt = w_win;
                MODE_PERIODIC: w_intr_nxt = (w_period == '0) ? w_win
                                          : (w_after_start && (w_phase_nxt < w_len));
                MODE_HOLD_ACK: w_intr_nxt = w_hold_nxt;
                default:       w_intr_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cfg   <= '0;
            r_phase <= '0;
            r_hold  <= 1'b0;
            r_intr  <= 1'b0;
        end else begin
            if (i_cfg_we) begin
                r_cfg <= i_cfg;
            end
            r_phase <= w_phase_nxt;
            r_hold  <= w_hold_nxt;
            r_intr  <= w_intr_nxt;
        end
    end

    assign o_intr = r_intr;

endmodule

// File: rtl/sim_intr_sched.sv
// Run/complete/timeout FSM with cycle counter and N programmable interrupt channels for a core harness.
// Latency: run/completed act on the next edge, all outputs registered; no backpressure, config writes dropped in RUN.
module sim_intr_sched
    import sim_intr_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_start,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             run,
    input  logic             completed,
    input  logic [N_CH-1:0]  intr_ack,
    output logic [N_CH-1:0]  intr,
    output logic [CNT_W-1:0] cycle,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] done_cycle
);

    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(MAX_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] w_cycle_nxt;
    logic [CNT_W-1:0] r_done_cycle;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic             w_enter;
    logic             w_adv;
    logic             w_latch_done;
    logic             w_cfg_wr;
    chan_cfg_t        w_cfg;
    logic [N_CH-1:0]  w_intr;

    always_comb begin
        w_state_nxt  = r_state;
        w_cycle_nxt  = r_cycle;
        w_enter      = 1'b0;
        w_adv        = 1'b0;
        w_latch_done = 1'b0;
        case (r_state)
            ST_RUN: begin
                // Completion checked first so it wins over the watchdog.
                if (completed) begin
                    w_state_nxt  = ST_DONE;
                    w_latch_done = 1'b1;
                end else if (r_cycle == LP_LIMIT) begin
                    w_state_nxt = ST_TIMEOUT;
                end else begin
                    w_cycle_nxt = r_cycle + 1'b1;
                    w_adv       = 1'b1;
                end
            end
            default: begin
                if (run) begin
                    w_state_nxt = ST_RUN;
                    w_cycle_nxt = '0;
                    w_enter     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_cycle      <= '0;
            r_done_cycle <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cycle   <= w_cycle_nxt;
            r_busy    <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
            r_timeout <= (w_state_nxt == ST_TIMEOUT);
            if (w_latch_done) begin
                r_done_cycle <= r_cycle;
            end
        end
    end

    assign w_cfg_wr = cfg_we && (r_state != ST_RUN);

    always_comb begin
        w_cfg        = '0;
        w_cfg.mode   = intr_mode_e'(cfg_mode);
        w_cfg.start  = CFG_W'(cfg_start);
        w_cfg.len    = CFG_W'(cfg_len);
        w_cfg.period = CFG_W'(cfg_period);
    end

    // Out-of-range channel numbers match no instance, so those writes are dropped.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        sim_intr_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk         (clk),
            .rstn        (rstn),
            .i_cfg_we    (w_cfg_wr && (cfg_ch == CH_W'(c))),
            .i_cfg       (w_cfg),
            .i_enter     (w_enter),
            .i_adv       (w_adv),
            .i_cycle_nxt (w_cycle_nxt),
            .i_ack       (intr_ack[c]),
            .o_intr      (w_intr[c])
        );
    end

    assign intr       = w_intr;
    assign cycle      = r_cycle;
    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign done_cycle = r_done_cycle;

endmodule

// File: tb/tb_sim_intr_sched.sv
// Directed bench for sim_intr_sched: per-cycle reference model feeds a scoreboard queue of expected outputs.
module tb_sim_intr_sched;
    import sim_intr_pkg::*;

    localparam int N_CH = 2;
    localparam int CNT_W = 32;
    localparam int MAXC = 501;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             cfg_we = 1'b0;
    logic [0:0]       cfg_ch = '0;
    logic [1:0]       cfg_mode = '0;
    logic [CNT_W-1:0] cfg_start = '0;
    logic [CNT_W-1:0] cfg_len = '0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic             run = 1'b0;
    logic             completed = 1'b0;
    logic [N_CH-1:0]  intr_ack = '0;
    logic [N_CH-1:0]  intr;
    logic [CNT_W-1:0] cycle;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] done_cycle;

    sim_intr_sched #(
        .N_CH(N_CH), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_period(cfg_period),
        .run(run), .completed(completed), .intr_ack(intr_ack), .intr(intr),
        .cycle(cycle), .busy(busy), .done(done), .timeout(timeout), .done_cycle(done_cycle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH-1:0]  intr;
        logic [CNT_W-1:0] cyc;
        logic             busy;
        logic             done;
        logic             tmo;
        logic [CNT_W-1:0] dc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    state_e           m_st = ST_IDLE;
    logic [CNT_W-1:0] m_cyc = '0;
    logic [CNT_W-1:0] m_dc = '0;
    logic [1:0]       m_mode[N_CH];
    logic [CNT_W-1:0] m_start[N_CH];
    logic [CNT_W-1:0] m_len[N_CH];
    logic [CNT_W-1:0] m_per[N_CH];
    logic             m_hold[N_CH];
    int               hi_cnt[N_CH];
    int               first_hi[N_CH];

    task automatic chk(input string tag, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = ST_IDLE;
        m_cyc = '0;
        m_dc = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_mode[c] = 2'd0; m_start[c] = '0; m_len[c] = '0; m_per[c] = '0; m_hold[c] = 1'b0;
        end
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < N_CH; c++) begin
            hi_cnt[c] = 0; first_hi[c] = -1;
        end
    endtask

    function automatic logic mode_fn(int c, logic [CNT_W-1:0] k);
        logic in_win;
        in_win = (k >= m_start[c]) && ((k - m_start[c]) < m_len[c]);
        case (m_mode[c])
            2'd1: return in_win;
            2'd2: begin
                if (m_per[c] == 0) return in_win;
                return (k >= m_start[c]) && (((k - m_start[c]) % m_per[c]) < m_len[c]);
            end
            2'd3: return m_hold[c];
            default: return 1'b0;
        endcase
    endfunction

    // Model the edge, queue the expectation, then clock and compare.
    task automatic cyc();
        exp_t   e;
        state_e nst;
        logic   enter;
        logic   adv;
        nst = m_st; enter = 1'b0; adv = 1'b0;
        if (m_st == ST_RUN) begin
            if (completed) begin
                nst = ST_DONE; m_dc = m_cyc;
            end else if (m_cyc == MAXC - 1) begin
                nst = ST_TIMEOUT;
            end else begin
                m_cyc = m_cyc + 1; adv = 1'b1;
            end
        end else if (run) begin
            nst = ST_RUN; m_cyc = '0; enter = 1'b1;
        end
        for (int c = 0; c < N_CH; c++) begin
            if (enter || intr_ack[c]) m_hold[c] = 1'b0;
            if ((enter || adv) && m_mode[c] == 2'd3 && m_cyc == m_start[c]) m_hold[c] = 1'b1;
            e.intr[c] = (nst == ST_RUN) ? mode_fn(c, m_cyc) : 1'b0;
        end
        e.cyc = m_cyc;
        e.busy = (nst == ST_RUN);
        e.done = (nst == ST_DONE);
        e.tmo = (nst == ST_TIMEOUT);
        e.dc = m_dc;
        if (m_st != ST_RUN && cfg_we) begin
            m_mode[cfg_ch] = cfg_mode; m_start[cfg_ch] = cfg_start;
            m_len[cfg_ch] = cfg_len; m_per[cfg_ch] = cfg_period;
        end
        m_st = nst;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("intr", CNT_W'(intr), CNT_W'(e.intr));
        chk("cycle", cycle, e.cyc);
        chk("busy", CNT_W'(busy), CNT_W'(e.busy));
        chk("done", CNT_W'(done), CNT_W'(e.done));
        chk("timeout", CNT_W'(timeout), CNT_W'(e.tmo));
        chk("done_cycle", done_cycle, e.dc);
        for (int c = 0; c < N_CH; c++) begin
            if (intr[c]) begin
                if (hi_cnt[c] == 0) first_hi[c] = int'(cycle);
                hi_cnt[c]++;
            end
        end
    endtask

    task automatic cfg_wr(input int ch, input logic [1:0] mode, input int st, input int ln, input int per);
        cfg_ch = ch[0:0]; cfg_mode = mode;
        cfg_start = CNT_W'(st); cfg_len = CNT_W'(ln); cfg_period = CNT_W'(per);
        cfg_we = 1'b1;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        cyc();
        run = 1'b0;
    endtask

    task automatic finish_run();
        completed = 1'b1;
        cyc();
        completed = 1'b0;
    endtask

    task automatic run_to(input int k);
        int guard = 0;
        while (!(m_st == ST_RUN && m_cyc == CNT_W'(k)) && guard < 2000) begin
            cyc();
            guard++;
        end
        chk("run_to_bound", CNT_W'(guard < 2000), CNT_W'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "global timeout");
    end

    initial begin
        model_reset();
        clr_cnt();
        #3 rstn = 1'b0;
        #1;
        chk("rst_intr", CNT_W'(intr), 0);
        chk("rst_cycle", cycle, 0);
        chk("rst_flags", CNT_W'({busy, done, timeout}), 0);
        chk("rst_done_cycle", done_cycle, 0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;

        // WINDOW start=100 len=200
        cfg_wr(0, 2'd1, 100, 200, 0);
        clr_cnt();
        pulse_run();
        chk("win_start_cycle", cycle, 0);
        run_to(400);
        finish_run();
        chk("win_hi_count", CNT_W'(hi_cnt[0]), 200);
        chk("win_first_hi", CNT_W'(first_hi[0]), 100);
        chk("win_done_cycle", done_cycle, 400);

        // PERIODIC start=50 period=10 len=3 until watchdog
        cfg_wr(0, 2'd0, 0, 0, 0);
        cfg_wr(1, 2'd2, 50, 3, 10);
        clr_cnt();
        pulse_run();
        for (int i = 0; i < 700 && m_st != ST_TIMEOUT; i++) cyc();
        chk("per_reached_timeout", CNT_W'(timeout), 1);
        repeat (3) cyc();
        chk("per_hi_count", CNT_W'(hi_cnt[1]), 136);
        chk("per_first_hi", CNT_W'(first_hi[1]), 50);
        chk("per_timeout_cycle", cycle, MAXC - 1);

        // HOLD_ACK: ch0 start=20 ack at 35; ch1 start=50 with ack coinciding with set
        cfg_wr(1, 2'd3, 50, 0, 0);
        cfg_wr(0, 2'd3, 20, 0, 0);
        clr_cnt();
        pulse_run();
        run_to(35);
        intr_ack = 2'b01; cyc(); intr_ack = 2'b00;
        run_to(49);
        intr_ack = 2'b10; cyc(); intr_ack = 2'b00;
        chk("hold_set_beats_ack", CNT_W'(intr[1]), 1);
        run_to(60);
        intr_ack = 2'b10; cyc(); intr_ack = 2'b00;
        run_to(100);
        finish_run();
        chk("hold0_hi_count", CNT_W'(hi_cnt[0]), 16);
        chk("hold0_first_hi", CNT_W'(first_hi[0]), 20);
        chk("hold1_hi_count", CNT_W'(hi_cnt[1]), 11);

        // completed coincides with the watchdog limit
        cfg_wr(0, 2'd0, 0, 0, 0);
        cfg_wr(1, 2'd0, 0, 0, 0);
        pulse_run();
        run_to(MAXC - 1);
        finish_run();
        chk("limit_done", CNT_W'(done), 1);
        chk("limit_no_timeout", CNT_W'(timeout), 0);
        chk("limit_done_cycle", done_cycle, 500);

        // config write during RUN is dropped; rewrite after DONE applies
        cfg_wr(0, 2'd1, 10, 5, 0);
        clr_cnt();
        pulse_run();
        run_to(3);
        cfg_wr(0, 2'd1, 5, 5, 0);
        run_to(30);
        finish_run();
        chk("cfg_run_hi_count", CNT_W'(hi_cnt[0]), 5);
        chk("cfg_run_first_hi", CNT_W'(first_hi[0]), 10);
        cfg_wr(0, 2'd1, 5, 5, 0);
        clr_cnt();
        pulse_run();
        chk("rerun_cycle_zero", cycle, 0);
        run_to(30);
        finish_run();
        chk("cfg_new_hi_count", CNT_W'(hi_cnt[0]), 5);
        chk("cfg_new_first_hi", CNT_W'(first_hi[0]), 5);

        // asynchronous reset mid-run
        cfg_wr(0, 2'd1, 0, 1000, 0);
        pulse_run();
        run_to(300);
        chk("pre_reset_intr", CNT_W'(intr[0]), 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_intr", CNT_W'(intr), 0);
        chk("arst_cycle", cycle, 0);
        chk("arst_flags", CNT_W'({busy, done, timeout}), 0);
        chk("arst_done_cycle", done_cycle, 0);
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        clr_cnt();
        pulse_run();
        run_to(50);
        finish_run();
        chk("post_reset_hi_count", CNT_W'(hi_cnt[0] + hi_cnt[1]), 0);
        chk("sb_drained", CNT_W'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
